nrisc_instruction_fetch: RTL and testbench

- Instruction fetch unit for the NRISC core.
- Produces the 16-bit instruction word consumed by the core's instruction decoder.
- Owns the PC register and runs a req/ack handshake with program memory.
- Computes the next PC from the decoder's PC control code and PC-advance strobe, so it is the producer end of the decoder's instruction and PC interface.

---
 rtl/nrisc_instruction_fetch.sv | 175 +++++++++++++++++
 tb/tb_nrisc_instruction_fetch.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrisc_instruction_fetch.sv
// NRISC instruction fetch unit.
// Owns the PC, fetches one 16-bit instruction word at a time from program
// memory over a req/ack handshake, presents it to the decoder and computes
// the next PC when the decoder signals that the instruction was consumed.
// A fetch that sees no ack within TIMEOUT wait cycles parks the unit in a
// sticky FAULT state that only rst leaves.
module nrisc_instruction_fetch #(
  parameter int                     PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = {PC_WIDTH{1'b0}},
  parameter int                     TIMEOUT      = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          CORE_PC_ctrl,
  input  logic                CORE_PC_clk,
  input  logic [15:0]         CORE_PC_offset,
  input  logic [PC_WIDTH-1:0] CORE_STACK_top,
  input  logic                CORE_halt,
  output logic [PC_WIDTH-1:0] CORE_PC_out,
  output logic [15:0]         CORE_InstructionOUT,
  output logic                CORE_InstructionValid,
  output logic [1:0]          CORE_Status,
  output logic [PC_WIDTH-1:0] MEM_addr,
  output logic                MEM_req,
  input  logic                MEM_ack,
  input  logic [15:0]         MEM_data
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] STAT_IDLE  = 2'b00;
  localparam logic [1:0] STAT_FETCH = 2'b01;
  localparam logic [1:0] STAT_VALID = 2'b10;
  localparam logic [1:0] STAT_FAULT = 2'b11;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_REL = 2'd1;
  localparam logic [1:0] PC_ABS = 2'd2;
  localparam logic [1:0] PC_RET = 2'd3;

  // Last counter value before the fault fires: the counter counts WAIT cycles
  // that ended without an ack, so hitting TIMEOUT-1 on another empty cycle
  // means TIMEOUT cycles have elapsed.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] mem_addr_r;
  logic                mem_req_r;
  logic [15:0]         instr_r;
  logic                valid_r;
  logic [1:0]          status_r;
  logic [7:0]          tmo_cnt_r;

  logic [PC_WIDTH-1:0] rel_ofs_s;
  logic [PC_WIDTH-1:0] abs_ofs_s;
  logic [PC_WIDTH-1:0] next_pc_s;

  // The offset is 16 bits wide; adapt it to the PC width (sign-extend for
  // relative jumps, zero-extend for absolute targets, truncate if narrower).
  generate
    if (PC_WIDTH > 16) begin : g_ofs_extend
      assign rel_ofs_s = {{(PC_WIDTH-16){CORE_PC_offset[15]}}, CORE_PC_offset};
      assign abs_ofs_s = {{(PC_WIDTH-16){1'b0}}, CORE_PC_offset};
    end else begin : g_ofs_trunc
      assign rel_ofs_s = CORE_PC_offset[PC_WIDTH-1:0];
      assign abs_ofs_s = CORE_PC_offset[PC_WIDTH-1:0];
    end
  endgenerate

  // Next-PC selection; all sums wrap naturally modulo 2^PC_WIDTH.
  always_comb begin
    next_pc_s = pc_r + PC_ONE;
    case (CORE_PC_ctrl)
      PC_INC:  next_pc_s = pc_r + PC_ONE;
      PC_REL:  next_pc_s = pc_r + rel_ofs_s;
      PC_ABS:  next_pc_s = abs_ofs_s;
      PC_RET:  next_pc_s = CORE_STACK_top;
      default: next_pc_s = pc_r + PC_ONE;
    endcase
  end

  // Fetch FSM with all outputs registered: each transition also sets the
  // output values that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_VECTOR;
      mem_addr_r <= RESET_VECTOR;
      mem_req_r  <= 1'b0;
      instr_r    <= 16'h0000;
      valid_r    <= 1'b0;
      status_r   <= STAT_IDLE;
      tmo_cnt_r  <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!CORE_halt) begin
            state_r    <= ST_FETCH;
            mem_req_r  <= 1'b1;
            mem_addr_r <= pc_r;
            status_r   <= STAT_FETCH;
          end
        end
        ST_FETCH: begin
          // Request has been on the bus for one cycle; start counting.
          state_r   <= ST_WAIT;
          tmo_cnt_r <= 8'd0;
        end
        ST_WAIT: begin
          // Halt is deliberately not looked at: a started fetch always completes.
          if (MEM_ack) begin
            state_r   <= ST_VALID;
            instr_r   <= MEM_data;
            mem_req_r <= 1'b0;
            valid_r   <= 1'b1;
            status_r  <= STAT_VALID;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r   <= ST_FAULT;
            mem_req_r <= 1'b0;
            valid_r   <= 1'b0;
            status_r  <= STAT_FAULT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        ST_VALID: begin
          // Instruction and PC stay frozen until the decoder consumes them.
          if (CORE_PC_clk) begin
            pc_r       <= next_pc_s;
            mem_addr_r <= next_pc_s;
            valid_r    <= 1'b0;
            if (CORE_halt) begin
              state_r  <= ST_IDLE;
              status_r <= STAT_IDLE;
            end else begin
              state_r   <= ST_FETCH;
              mem_req_r <= 1'b1;
              status_r  <= STAT_FETCH;
            end
          end
        end
        ST_FAULT: begin
          // Sticky until rst.
          mem_req_r <= 1'b0;
          valid_r   <= 1'b0;
          status_r  <= STAT_FAULT;
        end
        default: begin
          // An illegal state encoding is treated as a fault.
          state_r   <= ST_FAULT;
          mem_req_r <= 1'b0;
          valid_r   <= 1'b0;
          status_r  <= STAT_FAULT;
        end
      endcase
    end
  end

  assign CORE_PC_out           = pc_r;
  assign CORE_InstructionOUT   = instr_r;
  assign CORE_InstructionValid = valid_r;
  assign CORE_Status           = status_r;
  assign MEM_addr              = mem_addr_r;
  assign MEM_req               = mem_req_r;

endmodule

// File: tb/tb_nrisc_instruction_fetch.sv
// Scoreboard bench for nrisc_instruction_fetch.
// The stimulus process pushes expected fetch addresses, expected delivered
// instructions and expected signal snapshots into queues; a separate monitor
// process pops and compares them on the falling clock edge.
module tb_nrisc_instruction_fetch;

  localparam int SEL_STATUS = 0;
  localparam int SEL_VALID  = 1;
  localparam int SEL_REQ    = 2;
  localparam int SEL_PC     = 3;
  localparam int SEL_INSTR  = 4;
  localparam int SEL_ADDR   = 5;
  localparam int SEL_MEAS   = 6;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } instr_t;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
    int          meas;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  CORE_PC_ctrl;
  logic        CORE_PC_clk;
  logic [15:0] CORE_PC_offset;
  logic [15:0] CORE_STACK_top;
  logic        CORE_halt;
  logic [15:0] CORE_PC_out;
  logic [15:0] CORE_InstructionOUT;
  logic        CORE_InstructionValid;
  logic [1:0]  CORE_Status;
  logic [15:0] MEM_addr;
  logic        MEM_req;
  logic        MEM_ack;
  logic [15:0] MEM_data;

  logic        model_ack;
  logic        force_ack;
  logic        mem_never;
  int          mem_lat;
  int          mem_cnt;

  logic [15:0] addr_q[$];
  instr_t      instr_q[$];
  chk_t        chk_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nrisc_instruction_fetch #(
    .PC_WIDTH(16),
    .RESET_VECTOR(16'h0000),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .CORE_PC_ctrl(CORE_PC_ctrl),
    .CORE_PC_clk(CORE_PC_clk),
    .CORE_PC_offset(CORE_PC_offset),
    .CORE_STACK_top(CORE_STACK_top),
    .CORE_halt(CORE_halt),
    .CORE_PC_out(CORE_PC_out),
    .CORE_InstructionOUT(CORE_InstructionOUT),
    .CORE_InstructionValid(CORE_InstructionValid),
    .CORE_Status(CORE_Status),
    .MEM_addr(MEM_addr),
    .MEM_req(MEM_req),
    .MEM_ack(MEM_ack),
    .MEM_data(MEM_data)
  );

  // Program memory contents: a fixed word at 0, a simple pattern elsewhere.
  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0000) return 16'h8123;
    else return a ^ 16'hA5A5;
  endfunction

  assign MEM_data = memf(MEM_addr);
  assign MEM_ack  = model_ack | force_ack;

  // Memory model: counts cycles with req high (FETCH is count 1, first WAIT
  // is count 2) and acks after mem_lat extra WAIT cycles.
  initial begin
    model_ack = 1'b0;
    mem_cnt   = 0;
    forever begin
      @(posedge clk);
      #2;
      if (MEM_req === 1'b1) mem_cnt++;
      else mem_cnt = 0;
      model_ack = (MEM_req === 1'b1) && !mem_never && (mem_cnt == 2 + mem_lat);
    end
  end

  // Monitor: pops snapshot checks and scoreboard entries on the falling edge.
  initial begin
    chk_t        c;
    logic [15:0] got;
    logic [15:0] a;
    instr_t      e;
    logic        prev_req;
    logic        prev_valid;
    prev_req   = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        case (c.sel)
          SEL_STATUS: got = {14'd0, CORE_Status};
          SEL_VALID:  got = {15'd0, CORE_InstructionValid};
          SEL_REQ:    got = {15'd0, MEM_req};
          SEL_PC:     got = CORE_PC_out;
          SEL_INSTR:  got = CORE_InstructionOUT;
          SEL_ADDR:   got = MEM_addr;
          default:    got = 16'(c.meas);
        endcase
        n_cmp++;
        if (got !== c.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
        end
      end
      if (rst === 1'b0) begin
        if (MEM_req === 1'b1 && prev_req !== 1'b1) begin
          n_cmp++;
          if (addr_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_fetch: got addr %h expected no request", MEM_addr);
          end else begin
            a = addr_q.pop_front();
            if (MEM_addr !== a) begin
              n_err++;
              $display("FAIL fetch_addr: got %h expected %h", MEM_addr, a);
            end
          end
        end
        if (CORE_InstructionValid === 1'b1 && prev_valid !== 1'b1) begin
          n_cmp++;
          if (instr_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_valid: got instr %h expected no instruction", CORE_InstructionOUT);
          end else begin
            e = instr_q.pop_front();
            if (CORE_InstructionOUT !== e.data) begin
              n_err++;
              $display("FAIL instr_data: got %h expected %h", CORE_InstructionOUT, e.data);
            end
            n_cmp++;
            if (CORE_PC_out !== e.pc) begin
              n_err++;
              $display("FAIL instr_pc: got %h expected %h", CORE_PC_out, e.pc);
            end
            n_cmp++;
            if (CORE_Status !== 2'b10) begin
              n_err++;
              $display("FAIL valid_status: got %b expected 10", CORE_Status);
            end
          end
        end
      end
      prev_req   = MEM_req;
      prev_valid = CORE_InstructionValid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input string name, input int sel, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    c.meas = 0;
    chk_q.push_back(c);
  endtask

  task automatic expect_meas(input string name, input int got, input int exp);
    chk_t c;
    c.name = name;
    c.sel  = SEL_MEAS;
    c.exp  = 16'(exp);
    c.meas = got;
    chk_q.push_back(c);
  endtask

  task automatic push_fetch(input logic [15:0] addr, input bit with_instr);
    instr_t e;
    addr_q.push_back(addr);
    if (with_instr) begin
      e.pc   = addr;
      e.data = memf(addr);
      instr_q.push_back(e);
    end
  endtask

  // Counts post-edge samples until Valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (CORE_InstructionValid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // One-cycle consume strobe; ctrl/offset get junk afterwards, which must be ignored.
  task automatic pulse(input logic [1:0] ctrl, input logic [15:0] ofs, input logic [15:0] top);
    CORE_PC_ctrl   = ctrl;
    CORE_PC_offset = ofs;
    CORE_STACK_top = top;
    CORE_PC_clk    = 1'b1;
    tick();
    CORE_PC_clk    = 1'b0;
    CORE_PC_ctrl   = 2'd3;
    CORE_PC_offset = 16'hBEEF;
    CORE_STACK_top = 16'hDEAD;
  endtask

  // Consume, expect a fetch at exp_addr and the minimum 3-cycle latency.
  task automatic step(input logic [1:0] ctrl, input logic [15:0] ofs,
                      input logic [15:0] top, input logic [15:0] exp_addr);
    int n;
    push_fetch(exp_addr, 1'b1);
    pulse(ctrl, ofs, top);
    wait_valid(n);
    expect_meas("pc_clk_to_valid", n + 1, 3);
  endtask

  initial begin
    int n;
    rst = 1'b1; CORE_halt = 1'b0; CORE_PC_clk = 1'b0; CORE_PC_ctrl = 2'd0;
    CORE_PC_offset = 16'h0000; CORE_STACK_top = 16'h0000;
    force_ack = 1'b0; mem_never = 1'b0; mem_lat = 0;
    repeat (3) tick();
    expect_sig("rst_valid",  SEL_VALID,  16'h0000);
    expect_sig("rst_status", SEL_STATUS, 16'h0000);
    expect_sig("rst_req",    SEL_REQ,    16'h0000);
    expect_sig("rst_addr",   SEL_ADDR,   16'h0000);
    expect_sig("rst_instr",  SEL_INSTR,  16'h0000);
    expect_sig("rst_pc",     SEL_PC,     16'h0000);

    // First fetch from the reset vector with a zero-wait memory.
    push_fetch(16'h0000, 1'b1);
    rst = 1'b0;
    wait_valid(n);
    expect_meas("rst_to_valid", n, 3);

    // Next-PC modes.
    step(2'd2, 16'h0005, 16'h0000, 16'h0005);
    step(2'd1, 16'hFFFD, 16'h0000, 16'h0002);
    step(2'd2, 16'h0005, 16'h0000, 16'h0005);
    step(2'd2, 16'h0040, 16'h0000, 16'h0040);
    step(2'd3, 16'h0000, 16'h0123, 16'h0123);
    step(2'd1, 16'h0010, 16'h0000, 16'h0133);
    step(2'd2, 16'hFFFF, 16'h0000, 16'hFFFF);
    step(2'd0, 16'h0000, 16'h0000, 16'h0000);

    // Halt raised in WAIT, ack three cycles later.
    mem_lat = 3;
    push_fetch(16'h0001, 1'b1);
    pulse(2'd0, 16'h0000, 16'h0000);
    tick();
    expect_sig("halt_in_wait_status", SEL_STATUS, 16'h0001);
    CORE_halt = 1'b1;
    wait_valid(n);
    mem_lat = 0;
    expect_sig("halt_valid", SEL_VALID, 16'h0001);
    pulse(2'd0, 16'h0000, 16'h0000);
    expect_sig("halt_idle_status", SEL_STATUS, 16'h0000);
    expect_sig("halt_idle_pc",     SEL_PC,     16'h0002);
    repeat (4) tick();
    expect_sig("halt_no_req",      SEL_REQ,    16'h0000);
    expect_sig("halt_still_idle",  SEL_STATUS, 16'h0000);
    push_fetch(16'h0002, 1'b1);
    CORE_halt = 1'b0;
    wait_valid(n);
    expect_meas("resume_to_valid", n, 3);

    // Memory never acks: fault after 15 WAIT cycles, sticky until rst.
    mem_never = 1'b1;
    push_fetch(16'h0003, 1'b0);
    pulse(2'd0, 16'h0000, 16'h0000);
    n = 0;
    while (CORE_Status !== 2'b11 && n < 40) begin
      tick();
      n++;
    end
    expect_meas("wait_to_fault", n, 16);
    expect_sig("fault_req",   SEL_REQ,   16'h0000);
    expect_sig("fault_valid", SEL_VALID, 16'h0000);
    force_ack   = 1'b1;
    CORE_PC_clk = 1'b1;
    repeat (3) tick();
    force_ack   = 1'b0;
    CORE_PC_clk = 1'b0;
    tick();
    expect_sig("fault_sticky", SEL_STATUS, 16'h0003);
    expect_sig("fault_sticky_req", SEL_REQ, 16'h0000);
    rst = 1'b1;
    mem_never = 1'b0;
    tick();
    expect_sig("fault_rst_status", SEL_STATUS, 16'h0000);
    push_fetch(16'h0000, 1'b1);
    rst = 1'b0;
    wait_valid(n);
    expect_meas("fault_rst_to_valid", n, 3);

    // Reset in WAIT followed by a stale ack.
    mem_never = 1'b1;
    push_fetch(16'h0077, 1'b0);
    pulse(2'd2, 16'h0077, 16'h0000);
    tick();
    tick();
    expect_sig("abort_in_wait", SEL_STATUS, 16'h0001);
    rst = 1'b1;
    CORE_halt = 1'b1;
    tick();
    rst = 1'b0;
    expect_sig("abort_req",  SEL_REQ,  16'h0000);
    expect_sig("abort_pc",   SEL_PC,   16'h0000);
    expect_sig("abort_addr", SEL_ADDR, 16'h0000);
    force_ack = 1'b1;
    repeat (3) tick();
    force_ack = 1'b0;
    expect_sig("stale_ack_valid",  SEL_VALID,  16'h0000);
    expect_sig("stale_ack_status", SEL_STATUS, 16'h0000);
    mem_never = 1'b0;
    push_fetch(16'h0000, 1'b1);
    CORE_halt = 1'b0;
    wait_valid(n);
    expect_meas("abort_to_valid", n, 3);

    tick();
    expect_meas("addr_q_left",  addr_q.size(),  0);
    expect_meas("instr_q_left", instr_q.size(), 0);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
